// File: rtl/pc_fetch_if.sv
// Instruction-memory request/response bus between the fetch stage and memory.
interface pc_fetch_if;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_gnt;
  logic        inst_rvalid;
  logic [31:0] inst_rdata;

  // Fetch stage issues requests and consumes read data.
  modport master (
    output inst_req,
    output inst_addr,
    input  inst_gnt,
    input  inst_rvalid,
    input  inst_rdata
  );

  // Memory side accepts requests and returns read data.
  modport slave (
    input  inst_req,
    input  inst_addr,
    output inst_gnt,
    output inst_rvalid,
    output inst_rdata
  );
endinterface

// File: rtl/pc_fetch.sv
// Instruction fetch stage: holds the PC, issues one memory request at a time,
// captures the returned word for decode, and handles redirects.
// A redirect that arrives while a request is in flight marks the response
// for discard ("drop") rather than cancelling the bus transaction.
module pc_fetch (
  input  logic                cpu_clk,
  input  logic                cpu_rstn,
  input  logic [31:0]         npc,
  input  logic                jump_taken,
  input  logic                stall,
  output logic [31:0]         if_pc,
  output logic                if_valid,
  output logic [31:0]         if_inst,
  pc_fetch_if.master          bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_READY = 2'd2
  } state_e;

  localparam logic [31:0] RESET_PC = 32'h1C00_0000;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        drop_q, drop_d;
  logic        valid_q, valid_d;
  logic [31:0] inst_q, inst_d;

  assign if_pc         = pc_q;
  assign if_valid      = valid_q;
  assign if_inst       = inst_q;
  assign bus.inst_addr = pc_q;
  assign bus.inst_req  = (state_q == ST_IDLE) && cpu_rstn;

  // State and datapath registers; reset abandons any in-flight transaction.
  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      drop_q  <= 1'b0;
      valid_q <= 1'b0;
      inst_q  <= 32'h0000_0000;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      drop_q  <= drop_d;
      valid_q <= valid_d;
      inst_q  <= inst_d;
    end
  end

  // Next-state and datapath update; a redirect always wins over stall.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    drop_d  = drop_q;
    valid_d = valid_q;
    inst_d  = inst_q;
    case (state_q)
      ST_IDLE: begin
        if (jump_taken) begin
          pc_d = npc;
        end else begin
          pc_d = pc_q;
        end
        if (bus.inst_gnt) begin
          // Granted: the old PC is in flight; a same-cycle redirect drops it.
          state_d = ST_WAIT;
          drop_d  = jump_taken;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (jump_taken) begin
          pc_d = npc;
        end else begin
          pc_d = pc_q;
        end
        if (bus.inst_rvalid) begin
          if (drop_q || jump_taken) begin
            drop_d  = 1'b0;
            state_d = ST_IDLE;
          end else begin
            inst_d  = bus.inst_rdata;
            valid_d = 1'b1;
            state_d = ST_READY;
          end
        end else if (jump_taken) begin
          drop_d = 1'b1;
        end else begin
          drop_d = drop_q;
        end
      end
      ST_READY: begin
        if (jump_taken || !stall) begin
          pc_d    = npc;
          valid_d = 1'b0;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_READY;
        end
      end
      default: begin
        state_d = ST_IDLE;
        drop_d  = 1'b0;
        valid_d = 1'b0;
      end
    endcase
  end

endmodule
